// File: rtl/sd_crc_pkg.sv
// Shared constants and FSM state encoding for the SD DAT-line CRC16 engine.
package sd_crc_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int unsigned CRC_BEATS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRCP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sd_crc16_lane.sv
// One CCITT CRC16 register (zero seed) for a single DAT line.
// The register can be zeroed, stepped with a data bit, or shifted out MSB first.
module sd_crc16_lane
    import sd_crc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        zero_i,
    input  logic        step_i,
    input  logic        shift_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (zero_i) begin
            crc_d = '0;
        end else if (step_i) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (((bit_i ^ crc_q[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
        end else if (shift_i) begin
            crc_d = {crc_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_crc.sv
// Multi-lane CRC16 engine for the SD DAT path: generates/shifts out (TX) or checks (RX) one CRC per lane.
// Optional macro SD_CRC_ERRCNT_EN adds a saturating count of failed RX blocks (err_count/err_count_clr).
module sd_dat_crc
    import sd_crc_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int LEN_W  = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   dir,
    input  logic [LEN_W-1:0]       len_beats,
    input  logic                   beat,
    input  logic [NLANES-1:0]      data_in,
    output logic [NLANES-1:0]      crc_out,
    output logic                   crc_phase,
    output logic                   busy,
    output logic                   done,
    output logic [NLANES-1:0]      crc_err,
    output logic [16*NLANES-1:0]   crc
`ifdef SD_CRC_ERRCNT_EN
    ,
    input  logic                   err_count_clr,
    output logic [7:0]             err_count
`endif
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              dir_q, dir_d;
    logic [NLANES-1:0] err_q, err_d;
    logic [NLANES-1:0] msb;
    logic              zero_all, step_all, shift_all;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        dir_d     = dir_q;
        err_d     = err_q;
        zero_all  = 1'b0;
        step_all  = 1'b0;
        shift_all = 1'b0;
        if (clear) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            err_d    = '0;
            zero_all = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dir_d    = dir;
                        len_d    = len_beats;
                        cnt_d    = '0;
                        err_d    = '0;
                        zero_all = 1'b1;
                        state_d  = (len_beats != '0) ? ST_DATA : ST_CRCP;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        step_all = 1'b1;
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_CRCP;
                        end else begin
                            cnt_d = cnt_q + LEN_W'(1);
                        end
                    end
                end
                ST_CRCP: begin
                    if (beat) begin
                        shift_all = 1'b1;
                        // RX compares each received CRC bit against the MSB about to shift out.
                        if (!dir_q) begin
                            err_d = err_q | (data_in ^ msb);
                        end
                        if (cnt_q == LEN_W'(CRC_BEATS - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + LEN_W'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic [15:0] lane_crc;
        sd_crc16_lane u_lane (
            .clk_i   (clk),
            .rst_i   (reset),
            .zero_i  (zero_all),
            .step_i  (step_all),
            .shift_i (shift_all),
            .bit_i   (data_in[i]),
            .crc_o   (lane_crc)
        );
        assign msb[i]           = lane_crc[15];
        assign crc[16*i +: 16]  = lane_crc;
    end

    assign crc_phase = (state_q == ST_CRCP);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign crc_err   = err_q;
    assign crc_out   = (crc_phase && dir_q) ? msb : '0;

`ifdef SD_CRC_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (err_count_clr) begin
            errcnt_d = '0;
        end else if (done && !dir_q && (|err_q) && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_sd_dat_crc.sv
// Directed self-checking bench for sd_dat_crc (4 lanes); err_count checks build only with SD_CRC_ERRCNT_EN.
module tb_sd_dat_crc;

    localparam int NL = 4;
    localparam int LW = 13;
    localparam int TW = 16 * NL;

    logic          clk = 1'b0;
    logic          reset, clear, start, dir, beat;
    logic [LW-1:0] len_beats;
    logic [NL-1:0] data_in, crc_out, crc_err;
    logic          crc_phase, busy, done;
    logic [TW-1:0] crc;
`ifdef SD_CRC_ERRCNT_EN
    logic          err_count_clr;
    logic [7:0]    err_count;
`endif

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    sd_dat_crc #(.NLANES(NL), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .start     (start),
        .dir       (dir),
        .len_beats (len_beats),
        .beat      (beat),
        .data_in   (data_in),
        .crc_out   (crc_out),
        .crc_phase (crc_phase),
        .busy      (busy),
        .done      (done),
        .crc_err   (crc_err),
        .crc       (crc)
`ifdef SD_CRC_ERRCNT_EN
        ,
        .err_count_clr (err_count_clr),
        .err_count     (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC step written bit-by-bit from the polynomial taps.
    function automatic logic [15:0] mstep(input logic [15:0] c, input logic b);
        logic ci;
        ci = b ^ c[15];
        return {c[14:12], ci ^ c[11], c[10:5], ci ^ c[4], c[3:0], ci};
    endfunction

    function automatic logic [TW-1:0] exp_stream(input logic [TW-1:0] m);
        logic [TW-1:0] s;
        logic [NL-1:0] nib;
        s = '0;
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < NL; l++) nib[l] = m[16*l + 15 - k];
            s = {s[TW-NL-1:0], nib};
        end
        return s;
    endfunction

    task automatic run_block(input logic tx, input int len, input int gap, input int mode,
                             input int flip_lane, input int flip_bit,
                             output logic [TW-1:0] entry, output logic [TW-1:0] model,
                             output logic [TW-1:0] stream, output logic busy_ok,
                             output logic [NL-1:0] err_done, output logic done_now,
                             output logic done_next);
        logic [15:0]   m [NL];
        logic [NL-1:0] d;
        for (int l = 0; l < NL; l++) m[l] = '0;
        busy_ok = 1'b1;
        stream  = '0;
        dir = tx; len_beats = LW'(len); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            busy_ok &= busy;
            case (mode)
                0:       d = NL'($urandom);
                1:       d = '1;
                default: d = NL'(i * 5 + 3);
            endcase
            for (int l = 0; l < NL; l++) m[l] = mstep(m[l], d[l]);
            data_in = d; beat = 1'b1;
            tick();
            beat = 1'b0; data_in = '0;
            repeat (gap) begin busy_ok &= busy; tick(); end
        end
        for (int l = 0; l < NL; l++) model[16*l +: 16] = m[l];
        entry = crc;
        busy_ok &= crc_phase;
        done_now = 1'b0;
        err_done = '0;
        for (int k = 0; k < 16; k++) begin
            busy_ok &= busy;
            for (int l = 0; l < NL; l++) begin
                d[l] = m[l][15-k];
                if (l == flip_lane && (15 - k) == flip_bit) d[l] = ~d[l];
            end
            stream = {stream[TW-NL-1:0], crc_out};
            data_in = tx ? '0 : d; beat = 1'b1;
            tick();
            beat = 1'b0; data_in = '0;
            if (k == 15) begin
                done_now = done;
                err_done = crc_err;
            end else begin
                repeat (gap) begin busy_ok &= busy; tick(); end
            end
        end
        tick();
        done_next = done;
    endtask

    logic [TW-1:0] entry, model, stream, entry_a, stream_a, model_a;
    logic          bok, dn, dnx;
    logic [NL-1:0] errd;
    int            dc0;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; dir = 1'b0; beat = 1'b0;
        len_beats = '0; data_in = '0;
`ifdef SD_CRC_ERRCNT_EN
        err_count_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  TW'(busy), TW'(0));
        chk("rst_done",  TW'(done), TW'(0));
        chk("rst_crc",   crc, '0);
        chk("rst_err",   TW'(crc_err), TW'(0));
        chk("rst_out",   TW'({crc_out, crc_phase}), TW'(0));
        reset = 1'b0;
        tick();

        // TX, 4096 beats of all-ones: the classic 512-byte 0xFF block
        done_cnt = 0;
        run_block(1'b1, 4096, 0, 1, -1, 0, entry, model, stream, bok, errd, dn, dnx);
        chk("tx1_entry",  entry, {NL{16'h7FA1}});
        chk("tx1_stream", stream, exp_stream({NL{16'h7FA1}}));
        chk("tx1_done",   TW'(dn), TW'(1));
        chk("tx1_done2",  TW'(dnx), TW'(0));
        chk("tx1_busy",   TW'(bok), TW'(1));
        chk("tx1_idle",   TW'(busy), TW'(0));
        chk("tx1_crc0",   crc, '0);
        chk("tx1_dcnt",   TW'(done_cnt), TW'(1));

        // RX, 1024 random beats, clean CRC then lane 2 CRC bit 5 flipped
        run_block(1'b0, 1024, 0, 0, -1, 0, entry, model, stream, bok, errd, dn, dnx);
        chk("rx_entry",   entry, model);
        chk("rx_err",     TW'(errd), TW'(4'b0000));
        chk("rx_done",    TW'(dn), TW'(1));
        chk("rx_out0",    stream, '0);
        run_block(1'b0, 1024, 0, 0, 2, 5, entry, model, stream, bok, errd, dn, dnx);
        chk("rxf_entry",  entry, model);
        chk("rxf_err",    TW'(errd), TW'(4'b0100));
        chk("rxf_dcnt",   TW'(done_cnt), TW'(3));

        // Zero-length TX block goes straight to the CRC phase
        run_block(1'b1, 0, 0, 1, -1, 0, entry, model, stream, bok, errd, dn, dnx);
        chk("len0_entry", entry, '0);
        chk("len0_strm",  stream, '0);
        chk("len0_done",  TW'(dn), TW'(1));
        chk("len0_phase", TW'(bok), TW'(1));

        // Gapped beats must give the same result as ungapped
        run_block(1'b1, 8, 0, 2, -1, 0, entry_a, model_a, stream_a, bok, errd, dn, dnx);
        chk("g0_entry",   entry_a, model_a);
        chk("g0_stream",  stream_a, exp_stream(model_a));
        run_block(1'b1, 8, 2, 2, -1, 0, entry, model, stream, bok, errd, dn, dnx);
        chk("g2_entry",   entry, entry_a);
        chk("g2_stream",  stream, stream_a);
        chk("g2_busy",    TW'(bok), TW'(1));
        chk("g2_done",    TW'(dn), TW'(1));

        // clear with start in the same cycle at data beat 100
        dc0 = done_cnt;
        dir = 1'b1; len_beats = LW'(200); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) begin data_in = '1; beat = 1'b1; tick(); end
        data_in = '1; beat = 1'b1; clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0; beat = 1'b0; data_in = '0;
        chk("clr_busy",   TW'(busy), TW'(0));
        chk("clr_crc",    crc, '0);
        chk("clr_phase",  TW'(crc_phase), TW'(0));
        repeat (5) tick();
        chk("clr_ign",    TW'(busy), TW'(0));
        chk("clr_nodone", TW'(done_cnt), TW'(dc0));

        // Asynchronous reset in the middle of the CRC phase
        dir = 1'b1; len_beats = LW'(4); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) begin data_in = '1; beat = 1'b1; tick(); end
        repeat (3) begin data_in = '0; beat = 1'b1; tick(); end
        beat = 1'b0;
        chk("ar_phase",   TW'(crc_phase), TW'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("ar_crc",     crc, '0);
        chk("ar_ctl",     TW'({busy, crc_phase, done}), TW'(0));
        chk("ar_out",     TW'(crc_out), TW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("ar_nodone",  TW'(done_cnt), TW'(dc0));

`ifdef SD_CRC_ERRCNT_EN
        repeat (3) run_block(1'b0, 2, 0, 0, 0, 0, entry, model, stream, bok, errd, dn, dnx);
        chk("ec_three",   TW'(err_count), TW'(3));
        run_block(1'b0, 2, 0, 0, -1, 0, entry, model, stream, bok, errd, dn, dnx);
        chk("ec_good",    TW'(err_count), TW'(3));
        err_count_clr = 1'b1;
        tick();
        err_count_clr = 1'b0;
        chk("ec_clr",     TW'(err_count), TW'(0));
        repeat (300) run_block(1'b0, 2, 0, 0, 1, 3, entry, model, stream, bok, errd, dn, dnx);
        chk("ec_sat",     TW'(err_count), TW'(255));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
